// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with deglitching, frame checks, timeout and FWFT byte FIFO
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int PARITY_EN      = 1
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  PS2C_I,
  input  logic                  PS2D_I,
  input  logic                  ACK_I,
  input  logic                  CLR_I,
  output logic [7:0]            DAT_O,
  output logic                  VALID_O,
  output logic [DEPTH_LOG2:0]   COUNT_O,
  output logic                  OVERFLOW_O,
  output logic                  ERR_O,
  output logic [7:0]            ERRCNT_O
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [SYNC_STAGES-1:0] c_sync, d_sync;
  logic c_s, d_s, filt, fall;
  logic [7:0] fcnt;
  assign c_s = c_sync[SYNC_STAGES-1];
  assign d_s = d_sync[SYNC_STAGES-1];
  // filtered clock flips on the FILTER_LEN-th consecutive differing sample; fall is registered with it
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      c_sync <= '1;
      d_sync <= '1;
      filt   <= 1'b1;
      fcnt   <= '0;
      fall   <= 1'b0;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], PS2C_I};
      d_sync <= {d_sync[SYNC_STAGES-2:0], PS2D_I};
      fall   <= filt && !c_s && fcnt == 8'(FILTER_LEN - 1);
      fcnt   <= (c_s == filt || fcnt == 8'(FILTER_LEN - 1)) ? '0 : fcnt + 8'd1;
      if (c_s != filt && fcnt == 8'(FILTER_LEN - 1)) filt <= c_s;
    end
  state_t st, st_n;
  logic [2:0] bc, bc_n;
  logic [7:0] sh, sh_n;
  logic par, par_n, push, push_n, err_n;
  logic [TW-1:0] wd, wd_n;
  always_comb begin
    st_n   = st;
    bc_n   = bc;
    sh_n   = sh;
    par_n  = par;
    push_n = 1'b0;
    err_n  = 1'b0;
    wd_n   = (st == IDLE || fall) ? '0 : wd + TW'(1);
    if (fall)
      case (st)
        IDLE: begin
          st_n = d_s ? IDLE : DATA;
          bc_n = '0;
        end
        DATA: begin
          sh_n = {d_s, sh[7:1]};
          bc_n = bc + 3'd1;
          st_n = bc == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_n = d_s;
          st_n  = STOP;
        end
        default: begin
          push_n = d_s && (PARITY_EN == 0 || ^{sh, par});
          err_n  = !push_n;
          st_n   = IDLE;
        end
      endcase
    else if (st != IDLE && wd == TW'(TIMEOUT_CYCLES - 1)) begin
      err_n = 1'b1;
      st_n  = IDLE;
    end
  end
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      st       <= IDLE;
      bc       <= '0;
      sh       <= '0;
      par      <= 1'b0;
      wd       <= '0;
      push     <= 1'b0;
      ERR_O    <= 1'b0;
      ERRCNT_O <= '0;
    end else begin
      st       <= st_n;
      bc       <= bc_n;
      sh       <= sh_n;
      par      <= par_n;
      wd       <= wd_n;
      push     <= push_n;
      ERR_O    <= err_n;
      ERRCNT_O <= err_n ? ERRCNT_O + 8'(ERRCNT_O != 8'hff) : CLR_I ? '0 : ERRCNT_O;
    end
  // sh stays untouched while IDLE, so it still holds the byte in the cycle push is high
  logic [7:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp, rp, rp_n;
  logic [DEPTH_LOG2:0] cnt_n;
  logic pop, full, wr;
  assign pop   = VALID_O & ACK_I;
  assign full  = COUNT_O == (DEPTH_LOG2 + 1)'(DEPTH);
  assign wr    = push & (!full | pop);
  assign rp_n  = rp + DEPTH_LOG2'(pop);
  assign cnt_n = COUNT_O + (DEPTH_LOG2 + 1)'(wr) - (DEPTH_LOG2 + 1)'(pop);
  always_ff @(posedge CLK_I)
    if (wr) mem[wp] <= sh;
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      wp         <= '0;
      rp         <= '0;
      COUNT_O    <= '0;
      VALID_O    <= 1'b0;
      DAT_O      <= '0;
      OVERFLOW_O <= 1'b0;
    end else begin
      wp         <= wp + DEPTH_LOG2'(wr);
      rp         <= rp_n;
      COUNT_O    <= cnt_n;
      VALID_O    <= cnt_n != '0;
      DAT_O      <= cnt_n == '0 ? DAT_O : (wr && rp_n == wp) ? sh : mem[rp_n];
      OVERFLOW_O <= (push & full & !pop) | (!CLR_I & OVERFLOW_O);
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: randomized PS/2 frames scored against a queue model with a decoupled popping monitor
module tb_ps2_rx_fifo;
  localparam int S = 2, F = 4, TO = 600, D = 2, H = 20;
  logic clk = 0, rst_n = 0, ps2c = 1, ps2d = 1, mon_ack = 0, man_ack = 0, clr = 0, mon_en = 0;
  logic [7:0] dat, errcnt;
  logic valid, ovf, err;
  logic [D:0] count;
  logic [7:0] q[$];
  int total = 0, bad = 0, exp_err = 0, errp = 0, exp_errcnt = 0;
  logic exp_ovf = 0;
  always #5 clk = ~clk;
  ps2_rx_fifo #(.DEPTH_LOG2(D), .SYNC_STAGES(S), .FILTER_LEN(F), .TIMEOUT_CYCLES(TO), .PARITY_EN(1)) dut (
    .CLK_I(clk), .RST_I(rst_n), .PS2C_I(ps2c), .PS2D_I(ps2d), .ACK_I(mon_ack | man_ack), .CLR_I(clr),
    .DAT_O(dat), .VALID_O(valid), .COUNT_O(count), .OVERFLOW_O(ovf), .ERR_O(err), .ERRCNT_O(errcnt));
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function void err_model();
    exp_err++;
    if (exp_errcnt < 255) exp_errcnt++;
  endfunction
  always @(negedge clk) if (err) errp++;
  always @(negedge clk) begin
    mon_ack = 0;
    if (mon_en && valid && $urandom_range(1, 0) == 1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_q: DUT valid with model queue empty, dat=%0h", dat);
      end else begin
        chk("mon_dat", dat, q.pop_front());
        mon_ack = 1;
      end
    end
  end
  task automatic check_state(input string tag);
    chk({tag, ".count"}, count, q.size());
    chk({tag, ".valid"}, valid, q.size() != 0);
    if (q.size() != 0) chk({tag, ".dat"}, dat, q[0]);
    chk({tag, ".ovf"}, ovf, exp_ovf);
    chk({tag, ".errcnt"}, errcnt, exp_errcnt);
    chk({tag, ".errpulses"}, errp, exp_err);
  endtask
  task automatic send_frame(input logic [7:0] b, input int nbits = 11, input bit bad_par = 0,
                            input bit bad_stop = 0, input bit ack_at_stop = 0);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2d = f[i];
      repeat (H - 1) @(negedge clk);
      ps2c = 0;
      if (i == 10) begin
        if (bad_par || bad_stop) err_model();
        else if (ack_at_stop) begin
          void'(q.pop_front());
          q.push_back(b);
        end else if (q.size() < (1 << D)) q.push_back(b);
        else exp_ovf = 1;
        if (ack_at_stop) begin
          repeat (S + F + 1) @(posedge clk);
          @(negedge clk) man_ack = 1;
          @(negedge clk) man_ack = 0;
        end
      end
      repeat (H) @(negedge clk);
      ps2c = 1;
    end
    repeat (H) @(negedge clk);
    ps2d = 1;
  endtask
  task automatic man_pop(input string tag);
    @(negedge clk);
    if (q.size() != 0) chk(tag, dat, q.pop_front());
    man_ack = 1;
    @(negedge clk) man_ack = 0;
  endtask
  task automatic drain();
    int n = 0;
    mon_en = 1;
    while ((q.size() != 0 || valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < 2000, 1);
    mon_en = 0;
    @(negedge clk);
  endtask
  task automatic clr_pulse();
    @(negedge clk) clr = 1;
    @(negedge clk) clr = 0;
    exp_ovf = 0;
    exp_errcnt = 0;
  endtask
  initial begin
    int r, n;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset.dat", dat, 0);
    chk("reset.err", err, 0);
    rst_n = 1;
    repeat (5) @(negedge clk);
    send_frame(8'h1C);
    check_state("f1c");
    man_pop("pop1c");
    check_state("f1c_popped");
    send_frame(8'hF0);
    send_frame(8'h1C);
    check_state("two");
    man_pop("popf0");
    check_state("two_pop");
    man_pop("pop1c_b");
    send_frame(8'h1C, 11, 1, 0);
    check_state("badpar");
    send_frame(8'h1C, 11, 0, 1);
    check_state("badstop");
    clr_pulse();
    check_state("clr");
    send_frame(8'hA5, 5);
    repeat (TO + 50) @(negedge clk);
    err_model();
    check_state("timeout");
    send_frame(8'h5A);
    check_state("after_to");
    man_pop("pop5a");
    for (int i = 1; i <= 5; i++) send_frame(8'(i));
    check_state("overflow");
    clr_pulse();
    check_state("ovf_clr");
    send_frame(8'h06, 11, 0, 0, 1);
    check_state("full_pushpop");
    drain();
    check_state("drained");
    mon_en = 1;
    for (int k = 0; k < 25; k++) begin
      b = 8'($urandom);
      r = $urandom_range(9, 0);
      if (r == 0) begin
        n = $urandom_range(10, 2);
        send_frame(b, n);
        repeat (TO + 50) @(negedge clk);
        err_model();
      end else send_frame(b, 11, r <= 2, r == 3);
      chk("rand.errpulses", errp, exp_err);
    end
    drain();
    check_state("random");
    @(negedge clk) ps2d = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk) ps2c = 0;
      repeat (F - 1) @(negedge clk);
      ps2c = 1;
      repeat (20) @(negedge clk);
    end
    repeat (TO + 50) @(negedge clk);
    ps2d = 1;
    check_state("glitch");
    send_frame(8'h33, 4);
    @(negedge clk) rst_n = 0;
    q.delete();
    exp_ovf = 0;
    exp_errcnt = 0;
    repeat (3) @(negedge clk);
    check_state("midreset");
    chk("midreset.dat", dat, 0);
    rst_n = 1;
    repeat (5) @(negedge clk);
    send_frame(8'h29);
    check_state("f29");
    chk("f29.dat", dat, 8'h29);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver. It succeeds the fixed keyboard input path on the Nexys2 Kestrel-2 top level.
- Synchronises and deglitches PS2C/PS2D.
- Decodes 11-bit frames: start, 8 data LSB-first, odd parity, stop.
- Checks framing and parity; recovers from stalled frames by timeout.
- Queues good bytes in a first-word-fall-through FIFO for the CPU/IO fabric.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 bytes (1..8).
SYNC_STAGES, 2, synchroniser flops on each PS/2 line (>=2).
FILTER_LEN, 8, consecutive identical samples required before the filtered PS2C changes (1..255).
TIMEOUT_CYCLES, 100000, CLK_I cycles without a filtered PS2C falling edge before a partial frame is aborted (2 ms at 50 MHz).
PARITY_EN, 1, 1 = discard frames with bad odd parity; 0 = accept regardless.

Ports:
CLK_I  in  1  system clock (50 MHz nominal).
RST_I  in  1  asynchronous, active-low reset.
PS2C_I  in  1  raw PS/2 clock pin.
PS2D_I  in  1  raw PS/2 data pin.
ACK_I  in  1  pop request; effective only when VALID_O=1.
CLR_I  in  1  clears sticky OVERFLOW_O and ERRCNT_O.
DAT_O  out  8  FIFO head byte; valid while VALID_O=1.
VALID_O  out  1  FIFO non-empty.
COUNT_O  out  DEPTH_LOG2+1  bytes held, 0..2**DEPTH_LOG2.
OVERFLOW_O  out  1  sticky; a good byte was dropped because the FIFO was full.
ERR_O  out  1  one-cycle pulse on a framing, parity or timeout error.
ERRCNT_O  out  8  saturating error counter (stops at 255).

Behaviour:
- Reset (RST_I=0, asynchronous):
  - Outputs: DAT_O=0, VALID_O=0, COUNT_O=0, OVERFLOW_O=0, ERR_O=0, ERRCNT_O=0.
  - Internals: FSM=IDLE, synchronisers preset to 1 (bus idle), filtered clock=1, FIFO pointers=0.
- Reset mid-frame: the partial frame is discarded and FIFO contents are lost.
- Input conditioning:
  - Both lines pass through SYNC_STAGES flops.
  - Filtered PS2C changes only after FILTER_LEN consecutive synced samples that differ from its current value.
  - fall = one-cycle pulse on a filtered 1->0 transition.
  - PS2D is sampled from its synced value in the fall cycle.
- FSM, advancing only on fall:
  - IDLE: data=0 -> DATA (bitcnt=0); data=1 -> stay IDLE, no error.
  - DATA: shift right into shreg (LSB first); after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: data=1 and (PARITY_EN=0 or ^{shreg,parity}=1) -> push shreg, go IDLE. Otherwise -> ERR_O pulse, no push, go IDLE.
- Timeout:
  - Watchdog runs in DATA, PARITY and STOP, and reloads on each fall.
  - When it reaches TIMEOUT_CYCLES: ERR_O pulse, FSM -> IDLE, no push.
  - The watchdog is idle in IDLE.
- Latency: raw PS2C_I falling edge of the stop bit (data stable) -> VALID_O high after exactly SYNC_STAGES+FILTER_LEN+2 CLK_I cycles, with the FIFO previously empty.
- FIFO:
  - First-word fall-through. DAT_O is the head byte. Pop = VALID_O & ACK_I, taking effect at the next edge.
  - Push and pop in the same cycle:
    - Non-empty FIFO: both occur and COUNT_O is unchanged.
    - Empty FIFO: pop ignored, push occurs.
    - Full FIFO: both occur; the byte is accepted, no overflow.
  - Push when full with no pop: byte dropped, OVERFLOW_O<=1.
  - ACK_I while empty: ignored, no underflow.
  - Pointers wrap modulo 2**DEPTH_LOG2; COUNT_O disambiguates full from empty.
  - DAT_O holds its last value when empty.
- Error accounting:
  - ERRCNT_O increments on each ERR_O pulse and saturates at 255.
  - CLR_I zeroes ERRCNT_O and OVERFLOW_O at the next edge; a same-cycle set event wins over CLR_I.
- All outputs are registered; no combinational path from input to output.

Test Plan:
- Reset, then frame 0x1C (parity 0, stop 1) at 10 kHz PS2C -> VALID_O=1, DAT_O=0x1C, COUNT_O=1; ACK_I for 1 cycle -> VALID_O=0, COUNT_O=0.
- Frames 0xF0, 0x1C back-to-back, no ACK -> COUNT_O=2, DAT_O=0xF0; pop once -> DAT_O=0x1C.
- Frame 0x1C with parity=1, PARITY_EN=1 -> ERR_O one pulse, ERRCNT_O=1, COUNT_O=0; repeat with stop=0 -> ERRCNT_O=2; CLR_I -> ERRCNT_O=0.
- Start bit plus 4 data bits, then PS2C held high for TIMEOUT_CYCLES -> ERR_O pulse. The next full frame 0x5A must decode as DAT_O=0x5A.
- DEPTH_LOG2=2: send 5 frames 0x01..0x05 -> COUNT_O=4, OVERFLOW_O=1, drain yields 01,02,03,04. With FIFO full, ACK_I held while a 6th frame (0x06) completes in the same cycle -> COUNT_O stays 4, no new overflow.
- Glitch test: PS2C low pulses of FILTER_LEN-1 cycles -> no bit shifted, no ERR_O. Assert RST_I low mid-frame, release, send 0x29 -> DAT_O=0x29, COUNT_O=1.
